// File: rtl/dmac_channel_router_if.sv
// Channel-select handshake, shared DMAC strobes and per-channel outputs of the DMAC channel router.
// The master drives the selection and strobes; the slave (router) drives the routed outputs.
interface dmac_channel_router_if #(
    parameter int NUM_CH = 6,
    parameter int CH_W   = 3
);
    logic [CH_W-1:0]   DMACActivedChannel;
    logic              ChSelValid;
    logic              ChSelReady;
    logic              AutoFIFOReset;
    logic              ChRelease;
    logic              ReadDataEnable;
    logic              WriteDataEnable;
    logic              FIFOReset;
    logic              ErrorClear;
    logic [NUM_CH-1:0] ReadDataEnable_o;
    logic [NUM_CH-1:0] WriteDataEnable_o;
    logic [NUM_CH-1:0] FIFOReset_o;
    logic [CH_W-1:0]   CurrentChannel;
    logic              ChannelActive;
    logic              ChannelError;

    modport master (
        output DMACActivedChannel, ChSelValid, AutoFIFOReset, ChRelease,
               ReadDataEnable, WriteDataEnable, FIFOReset, ErrorClear,
        input  ChSelReady, ReadDataEnable_o, WriteDataEnable_o, FIFOReset_o,
               CurrentChannel, ChannelActive, ChannelError
    );

    modport slave (
        input  DMACActivedChannel, ChSelValid, AutoFIFOReset, ChRelease,
               ReadDataEnable, WriteDataEnable, FIFOReset, ErrorClear,
        output ChSelReady, ReadDataEnable_o, WriteDataEnable_o, FIFOReset_o,
               CurrentChannel, ChannelActive, ChannelError
    );
endinterface

// File: rtl/dmac_channel_router.sv
// Routes the shared DMAC strobes to one of NUM_CH channel FIFOs with break-before-make switching,
// an optional automatic FIFO-reset pulse on a newly selected channel and a sticky range error.
module dmac_channel_router #(
    parameter int NUM_CH     = 6,
    parameter int CH_W       = 3,
    parameter int RST_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    dmac_channel_router_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_RSTPULSE = 2'd2,
        S_ACTIVE   = 2'd3
    } state_t;

    localparam logic [CH_W:0] LP_NUM_CH   = (CH_W + 1)'(NUM_CH);
    localparam logic [3:0]    LP_CNT_LOAD = 4'(RST_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_cnt;
    logic [CH_W-1:0]   r_cur;
    logic              r_auto;
    logic              r_active;
    logic              r_err;
    logic [NUM_CH-1:0] r_rd_o;
    logic [NUM_CH-1:0] r_wr_o;
    logic [NUM_CH-1:0] r_fr_o;
    logic              w_ready;
    logic              w_accept;
    logic              w_bad;
    logic              w_switch;
    logic              w_forward;
    logic [NUM_CH-1:0] w_onehot;

    assign w_accept  = bus.ChSelValid & w_ready;
    assign w_bad     = ({1'b0, bus.DMACActivedChannel} >= LP_NUM_CH);
    // A valid select only moves the channel when it targets a different one (or from IDLE).
    assign w_switch  = w_accept & ~w_bad &
                       ((r_state == S_IDLE) | (bus.DMACActivedChannel != r_cur));
    assign w_forward = (r_state == S_ACTIVE) & (w_next_state == S_ACTIVE);
    assign w_onehot  = NUM_CH'(1'b1) << r_cur;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an accept in ACTIVE takes priority over ChRelease.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_switch) w_next_state = S_FLUSH;
                else          w_next_state = S_IDLE;
            end
            S_FLUSH: begin
                if (r_auto) w_next_state = S_RSTPULSE;
                else        w_next_state = S_ACTIVE;
            end
            S_RSTPULSE: begin
                if (r_cnt == 4'd0) w_next_state = S_ACTIVE;
                else               w_next_state = S_RSTPULSE;
            end
            S_ACTIVE: begin
                if (w_switch)                          w_next_state = S_FLUSH;
                else if (bus.ChRelease && !w_accept)   w_next_state = S_IDLE;
                else                                   w_next_state = S_ACTIVE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake output, decoded from the current state only.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:   w_ready = 1'b1;
            S_ACTIVE: w_ready = 1'b1;
            default:  w_ready = 1'b0;
        endcase
    end

    // Selected channel, pending auto-reset request and reset-pulse counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cur  <= '0;
            r_auto <= 1'b0;
            r_cnt  <= 4'd0;
        end else begin
            if (w_switch) begin
                r_cur  <= bus.DMACActivedChannel;
                r_auto <= bus.AutoFIFOReset;
            end
            if (r_state == S_FLUSH) begin
                r_cnt <= LP_CNT_LOAD;
            end else if ((r_state == S_RSTPULSE) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Registered per-channel outputs, status and sticky error (set beats clear).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rd_o   <= '0;
            r_wr_o   <= '0;
            r_fr_o   <= '0;
            r_active <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rd_o   <= (w_forward && bus.ReadDataEnable)  ? w_onehot : '0;
            r_wr_o   <= (w_forward && bus.WriteDataEnable) ? w_onehot : '0;
            r_fr_o   <= ((w_next_state == S_RSTPULSE) || (w_forward && bus.FIFOReset)) ? w_onehot : '0;
            r_active <= (w_next_state == S_ACTIVE);
            if (w_accept && w_bad)     r_err <= 1'b1;
            else if (bus.ErrorClear)   r_err <= 1'b0;
        end
    end

    assign bus.ChSelReady        = w_ready;
    assign bus.ReadDataEnable_o  = r_rd_o;
    assign bus.WriteDataEnable_o = r_wr_o;
    assign bus.FIFOReset_o       = r_fr_o;
    assign bus.CurrentChannel    = r_cur;
    assign bus.ChannelActive     = r_active;
    assign bus.ChannelError      = r_err;
endmodule

// File: doc/dmac_channel_router.md
Name: dmac_channel_router

Overview:
- Parametrised, registered successor to the DMAC per-channel enable decoder.
- Routes the shared DMAC strobes (ReadDataEnable, WriteDataEnable, FIFOReset) to one of NUM_CH channel FIFOs.
- Channel selection uses a valid/ready handshake and switches break-before-make.
- An optional automatic FIFO-reset pulse is issued to a newly selected channel, and out-of-range selections are flagged with a sticky error.

Parameters:
NUM_CH, 6, number of channel FIFOs (2..16)
CH_W, 3, width of channel index; must satisfy 2**CH_W >= NUM_CH
RST_CYCLES, 2, length in cycles of the automatic FIFO-reset pulse (1..15)

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous active-high reset
DMACActivedChannel  input  CH_W  requested channel index
ChSelValid  input  1  channel-select request
ChSelReady  output  1  router can accept a select
AutoFIFOReset  input  1  sampled with an accepted select; 1 = pulse the new channel's FIFO reset
ChRelease  input  1  release the current channel, returning to idle
ReadDataEnable  input  1  shared read strobe
WriteDataEnable  input  1  shared write strobe
FIFOReset  input  1  shared software FIFO reset
ReadDataEnable_o  output  NUM_CH  per-channel read strobe, one-hot or zero
WriteDataEnable_o  output  NUM_CH  per-channel write strobe, one-hot or zero
FIFOReset_o  output  NUM_CH  per-channel FIFO reset, one-hot or zero
CurrentChannel  output  CH_W  latched channel index
ChannelActive  output  1  high in ACTIVE
ChannelError  output  1  sticky out-of-range flag
ErrorClear  input  1  clears ChannelError

Behaviour:
- Reset (async assert, sync release):
  - all *_o = 0, CurrentChannel = 0, ChannelActive = 0, ChannelError = 0.
  - state = IDLE, reset counter = 0.
  - Asserting Reset mid-operation aborts any FLUSH/RSTPULSE immediately; outputs go 0 asynchronously.
- States: IDLE, FLUSH, RSTPULSE, ACTIVE.
- ChSelReady = 1 in IDLE and ACTIVE, 0 in FLUSH and RSTPULSE. It is combinational from state only.
- Accept = ChSelValid & ChSelReady.
- Accept with DMACActivedChannel >= NUM_CH:
  - ChannelError set next cycle.
  - State and CurrentChannel unchanged; the request is consumed.
- Valid accept in IDLE: latch CurrentChannel and AutoFIFOReset; go to FLUSH.
- Valid accept in ACTIVE, different channel: same as IDLE accept; all *_o go 0 on the next edge.
- Valid accept in ACTIVE, same channel: stay in ACTIVE, no flush, no reset pulse; the new AutoFIFOReset value is ignored.
- FLUSH: exactly 1 cycle with all *_o = 0 (guard gap).
  - Next state is RSTPULSE if the latched AutoFIFOReset = 1, else ACTIVE.
- RSTPULSE:
  - FIFOReset_o[CurrentChannel] = 1 for exactly RST_CYCLES consecutive cycles; read/write outputs stay 0.
  - Counter loads RST_CYCLES-1 on entry, decrements each cycle, and exits to ACTIVE at 0.
- ACTIVE:
  - Registered routing with 1-cycle latency: inputs sampled at edge N appear on bit CurrentChannel of ReadDataEnable_o, WriteDataEnable_o and FIFOReset_o after edge N. All other bits stay 0.
  - Inputs are forwarded from the cycle after entering ACTIVE onward.
- ChRelease in ACTIVE (no accept in the same cycle): go to IDLE; all *_o = 0 after the edge; CurrentChannel holds its value.
  - ChRelease together with an accept: the accept wins and ChRelease is ignored.
  - ChRelease is ignored in IDLE, FLUSH and RSTPULSE.
- ChannelActive = (state == ACTIVE), registered.
- ChannelError:
  - Set has priority over ErrorClear in the same cycle.
  - Otherwise ErrorClear clears it on the next edge.
- Invariant: at most one bit set across each *_o vector at all times.
- Strobes arriving outside ACTIVE are dropped, not queued.

Test Plan:
- Reset, then ChSelValid with channel 3 and AutoFIFOReset=0 -> 1 FLUSH cycle; ChannelActive=1 on the 2nd edge; ReadDataEnable=1 at edge N gives ReadDataEnable_o=6'b001000 after N; other channels stay 0.
- Select channel 2 with AutoFIFOReset=1, RST_CYCLES=2 -> FIFOReset_o=6'b000100 for exactly 2 cycles after FLUSH; ChSelReady=0 across FLUSH+RSTPULSE (3 cycles); then ACTIVE.
- ACTIVE on channel 1 with WriteDataEnable held high, then select channel 4 -> WriteDataEnable_o goes 6'b000010 -> 0 (FLUSH) -> 6'b010000; never two bits high.
- Select channel 6 or 7 with NUM_CH=6 -> ChannelError=1, state and CurrentChannel unchanged. ErrorClear and a bad select in the same cycle -> error stays 1. ErrorClear alone -> 0.
- ACTIVE on channel 5, ChRelease and a select of channel 0 in the same cycle -> FLUSH toward channel 0. ChRelease alone -> IDLE, all outputs 0. Reselecting channel 5 while ACTIVE on 5 -> no FLUSH cycle.
- Assert Reset during RSTPULSE -> FIFOReset_o=0 immediately; after release, state IDLE and ChSelReady=1.
